// File: rtl/uart_pkg.sv
// Purpose : shared types for the UART transmit/receive blocks.
// Latency : n/a (types and helpers only).
// Backpres: n/a.
package uart_pkg;

    // Parity select as presented on the configuration port; code 3 also means none.
    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } par_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // True when a parity bit is inserted into the frame.
    function automatic logic par_active(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Purpose : generic synchronous FIFO (push/pop/full/empty/level), shared by UART tx and rx.
// Latency : a pushed word is visible at pop_dat one cycle after the push edge.
// Backpres: push ignored while full, pop ignored while empty; level never exceeds DEPTH.
// Ports   : core_clk/arst_n clock and async active-low reset; push/push_dat write side;
//           pop/pop_dat read side (pop_dat is the head word); full, empty, level status.
module uart_fifo #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       core_clk,
    input  logic                       arst_n,
    input  logic                       push,
    input  logic [DWIDTH-1:0]          push_dat,
    input  logic                       pop,
    output logic [DWIDTH-1:0]          pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (do_pop && !do_push) begin
                level <= level - 1'b1;
            end
        end
    end

    // Storage needs no reset: pointers and level define what is valid.
    always_ff @(posedge core_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/uart_tx_core.sv
// Purpose : UART transmitter: FIFO-buffered words framed as start/data/parity/stop on tx_o.
// Latency : word accepted into an idle, empty core with en_i=1 starts its start bit one edge later.
// Backpres: ready_o = FIFO not full; frames run back to back while en_i=1 and words are queued.
// Ports   : main_clk_i/main_rst_an_i clock and async active-low reset; en_i, div_i, par_i,
//           stop2_i run-time config (sampled at frame start); data_i/valid_i/ready_o write stream;
//           tx_o serial line (idle high); busy_o activity flag; level_o FIFO fill level.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int DWIDTH   = 8,
    parameter int DEPTH    = 4,
    parameter int DIVWIDTH = 16
) (
    input  logic                       main_clk_i,
    input  logic                       main_rst_an_i,
    input  logic                       en_i,
    input  logic [DIVWIDTH-1:0]        div_i,
    input  logic [1:0]                 par_i,
    input  logic                       stop2_i,
    input  logic [DWIDTH-1:0]          data_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic                       tx_o,
    output logic                       busy_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int IW = $clog2(DWIDTH);

    logic [DWIDTH-1:0]   head_dat;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    logic                start_ok;
    logic                bit_end;
    logic                frame_end;

    tx_state_e           state;
    logic [DIVWIDTH-1:0] baud_cnt;
    logic [DIVWIDTH-1:0] div_q;
    logic [IW-1:0]       bit_idx;
    logic [DWIDTH-1:0]   shift_q;
    logic                par_en_q;
    logic                par_bit_q;
    logic                stop2_q;
    logic                stop_second;
    logic                tx_q;

    uart_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .core_clk (main_clk_i),
        .arst_n   (main_rst_an_i),
        .push     (valid_i),
        .push_dat (data_i),
        .pop      (pop),
        .pop_dat  (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (level_o)
    );

    assign ready_o   = !fifo_full;
    assign start_ok  = en_i && !fifo_empty;
    assign bit_end   = (baud_cnt == '0);
    assign frame_end = (state == ST_STOP) && bit_end && (!stop2_q || stop_second);
    // A new frame starts from idle, or straight out of the last stop bit with no gap.
    assign pop       = start_ok && ((state == ST_IDLE) || frame_end);

    // Both terms are registered and the state never passes through IDLE between
    // back-to-back frames, so busy_o stays high across frame boundaries.
    assign busy_o    = (state != ST_IDLE) || (level_o != '0);
    assign tx_o      = tx_q;

    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            state       <= ST_IDLE;
            baud_cnt    <= '0;
            div_q       <= '0;
            bit_idx     <= '0;
            shift_q     <= '0;
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
            stop2_q     <= 1'b0;
            stop_second <= 1'b0;
            tx_q        <= 1'b1;
        end else if (pop) begin
            // Frame start: capture word and configuration for the whole frame.
            state       <= ST_START;
            tx_q        <= 1'b0;
            baud_cnt    <= div_i;
            div_q       <= div_i;
            shift_q     <= head_dat;
            par_en_q    <= par_active(par_i);
            par_bit_q   <= (^head_dat) ^ (par_i == PAR_ODD);
            stop2_q     <= stop2_i;
            stop_second <= 1'b0;
            bit_idx     <= '0;
        end else if (state != ST_IDLE) begin
            if (!bit_end) begin
                baud_cnt <= baud_cnt - 1'b1;
            end else begin
                baud_cnt <= div_q;
                case (state)
                    ST_START: begin
                        state <= ST_DATA;
                        tx_q  <= shift_q[0];
                    end
                    ST_DATA: begin
                        if (bit_idx == IW'(DWIDTH - 1)) begin
                            if (par_en_q) begin
                                state <= ST_PARITY;
                                tx_q  <= par_bit_q;
                            end else begin
                                state <= ST_STOP;
                                tx_q  <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end
                    ST_PARITY: begin
                        state <= ST_STOP;
                        tx_q  <= 1'b1;
                    end
                    ST_STOP: begin
                        stop_second <= 1'b1;
                        if (frame_end) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
module tb_uart_tx_core;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int DIVW  = 16;
    localparam int LW    = $clog2(DEPTH + 1);

    typedef bit frame_t [16];

    logic            main_clk_i    = 1'b0;
    logic            main_rst_an_i = 1'b0;
    logic            en_i          = 1'b0;
    logic [DIVW-1:0] div_i         = '0;
    logic [1:0]      par_i         = 2'd0;
    logic            stop2_i       = 1'b0;
    logic [DW-1:0]   data_i        = '0;
    logic            valid_i       = 1'b0;
    logic            ready_o;
    logic            tx_o;
    logic            busy_o;
    logic [LW-1:0]   level_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int acc_cyc = 0;

    // Reference model: words accepted but not yet started, and observed frame timing.
    logic [DW-1:0] exp_q [$];
    int            start_log [$];
    int            end_log [$];

    bit              in_frame = 1'b0;
    int              k = 0;
    int              cur_n = 0;
    int              cur_div = 0;
    frame_t          cur_bits;
    frame_t          obs_bits;
    logic [DW-1:0]   mon_w;
    logic [DIVW-1:0] div_s = '0;
    logic [1:0]      par_s = 2'd0;
    logic            stop2_s = 1'b0;

    uart_tx_core #(
        .DWIDTH   (DW),
        .DEPTH    (DEPTH),
        .DIVWIDTH (DIVW)
    ) dut (
        .main_clk_i    (main_clk_i),
        .main_rst_an_i (main_rst_an_i),
        .en_i          (en_i),
        .div_i         (div_i),
        .par_i         (par_i),
        .stop2_i       (stop2_i),
        .data_i        (data_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .tx_o          (tx_o),
        .busy_o        (busy_o),
        .level_o       (level_o)
    );

    always #5 main_clk_i = ~main_clk_i;
    always @(posedge main_clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected line levels of one frame, one entry per bit period.
    function automatic int build(input logic [DW-1:0] d, input logic [1:0] p,
                                 input logic s2, output frame_t b);
        int n;
        b = '{default: 1'b1};
        b[0] = 1'b0;
        for (int i = 0; i < DW; i++) b[1+i] = d[i];
        n = 1 + DW;
        if (p == 2'd1 || p == 2'd2) begin
            b[n] = (^d) ^ (p == 2'd2);
            n++;
        end
        n += s2 ? 2 : 1;
        return n;
    endfunction

    function automatic logic [31:0] pack_obs(input int n);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v[i] = obs_bits[i];
        return v;
    endfunction

    // Line monitor: decodes frames against the model and checks status outputs every cycle.
    always @(negedge main_clk_i) begin
        if (!main_rst_an_i) begin
            in_frame = 1'b0;
            exp_q.delete();
        end else begin
            if (!in_frame && tx_o === 1'b0) begin
                chk("frame_has_word", 32'(exp_q.size() != 0), 1);
                mon_w = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                cur_n   = build(mon_w, par_s, stop2_s, cur_bits);
                cur_div = int'(div_s);
                in_frame = 1'b1;
                k = 0;
                start_log.push_back(cyc);
            end
            if (in_frame) begin
                chk("tx_bit", 32'(tx_o), 32'(cur_bits[k / (cur_div + 1)]));
                chk("busy_frame", 32'(busy_o), 1);
                if (k % (cur_div + 1) == 0) obs_bits[k / (cur_div + 1)] = tx_o;
                k++;
                if (k == cur_n * (cur_div + 1)) begin
                    in_frame = 1'b0;
                    end_log.push_back(cyc);
                end
            end else begin
                chk("busy_idle", 32'(busy_o), 32'(exp_q.size() != 0));
            end
            chk("level", 32'(level_o), 32'(exp_q.size()));
            chk("ready", 32'(ready_o), 32'(exp_q.size() < DEPTH));
        end
        // Inputs seen here are the ones the next rising edge will sample.
        div_s   = div_i;
        par_s   = par_i;
        stop2_s = stop2_i;
    end

    task automatic step(input int n);
        repeat (n) @(posedge main_clk_i);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        bit rdy = 1'b0;
        int t = 0;
        valid_i = 1'b1;
        data_i  = d;
        while (!rdy && t < 3000) begin
            @(negedge main_clk_i);
            rdy = ready_o;
            @(posedge main_clk_i);
            #1;
            t++;
        end
        if (rdy) begin
            exp_q.push_back(d);
            acc_cyc = cyc;
        end
        valid_i = 1'b0;
        chk("push_accepted", 32'(rdy), 1);
    endtask

    task automatic wait_drain(input int budget);
        int t = 0;
        while ((exp_q.size() != 0 || in_frame) && t < budget) begin
            step(1);
            t++;
        end
        chk("drain", 32'(exp_q.size()) + 32'(in_frame), 0);
        step(2);
    endtask

    task automatic wait_start(input int n0);
        int t = 0;
        while (start_log.size() <= n0 && t < 1000) begin
            step(1);
            t++;
        end
        chk("start_seen", 32'(start_log.size() > n0), 1);
    endtask

    task automatic wait_end(input int n0);
        int t = 0;
        while (end_log.size() <= n0 && t < 1000) begin
            step(1);
            t++;
        end
        chk("end_seen", 32'(end_log.size() > n0), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ns;
        int ne;

        // Reset values
        repeat (3) @(negedge main_clk_i);
        chk("rst_tx", 32'(tx_o), 1);
        chk("rst_ready", 32'(ready_o), 1);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_level", 32'(level_o), 0);
        step(1);
        main_rst_an_i = 1'b1;
        step(2);

        // 0xA5, 4-cycle bits, no parity, one stop bit
        div_i = 16'd3; par_i = 2'd0; stop2_i = 1'b0; en_i = 1'b1;
        push(8'hA5);
        wait_drain(500);
        chk("a5_latency", 32'(start_log[$] - acc_cyc), 1);
        chk("a5_length", 32'(end_log[$] - start_log[$] + 1), 40);
        chk("a5_bits", pack_obs(10), 32'h34A);

        // Parity and stop-bit variants at one cycle per bit
        div_i = 16'd0; par_i = 2'd1;
        push(8'h07);
        wait_drain(500);
        chk("par_even", 32'(obs_bits[9]), 1);
        par_i = 2'd2;
        push(8'h07);
        wait_drain(500);
        chk("par_odd", 32'(obs_bits[9]), 0);
        stop2_i = 1'b1;
        push(8'h07);
        wait_drain(500);
        chk("stop2_length", 32'(end_log[$] - start_log[$] + 1), 12);

        // Fill with enable low, fifth word held, then five frames back to back
        div_i = 16'd0; par_i = 2'd0; stop2_i = 1'b0; en_i = 1'b0;
        ns = start_log.size();
        fork
            begin
                for (int i = 0; i < 5; i++) push(DW'(8'h30 + i));
            end
            begin
                step(10);
                chk("full_level", 32'(level_o), 4);
                chk("full_ready", 32'(ready_o), 0);
                chk("full_no_start", 32'(start_log.size() - ns), 0);
                en_i = 1'b1;
            end
        join
        wait_drain(1000);
        chk("b2b_frames", 32'(start_log.size() - ns), 5);
        chk("b2b_span", 32'(end_log[$] - start_log[ns] + 1), 50);

        // Enable dropped during DATA of the first of two queued words
        en_i = 1'b0; div_i = 16'd1;
        push(8'h5C);
        push(8'hC3);
        ns = start_log.size();
        ne = end_log.size();
        en_i = 1'b1;
        wait_start(ns);
        step(6);
        en_i = 1'b0;
        wait_end(ne);
        step(10);
        chk("endrop_tx", 32'(tx_o), 1);
        chk("endrop_busy", 32'(busy_o), 1);
        chk("endrop_level", 32'(level_o), 1);
        chk("endrop_frames", 32'(start_log.size() - ns), 1);
        en_i = 1'b1;
        wait_drain(500);

        // Divider change mid-frame applies from the next frame
        div_i = 16'd3;
        ns = start_log.size();
        ne = end_log.size();
        push(8'h96);
        push(8'h69);
        wait_start(ns);
        step(10);
        div_i = 16'd1;
        wait_drain(1000);
        chk("div_old", 32'(end_log[ne] - start_log[ns] + 1), 40);
        chk("div_new", 32'(end_log[ne+1] - start_log[ns+1] + 1), 20);
        chk("div_no_gap", 32'(start_log[ns+1] - end_log[ne]), 1);

        // Reset in the middle of DATA with words still queued
        div_i = 16'd3;
        push(8'hF0);
        push(8'h0F);
        push(8'hAA);
        wait_start(start_log.size() - 1);
        step(9);
        #1 main_rst_an_i = 1'b0;
        #1;
        chk("midrst_tx", 32'(tx_o), 1);
        chk("midrst_level", 32'(level_o), 0);
        chk("midrst_busy", 32'(busy_o), 0);
        chk("midrst_ready", 32'(ready_o), 1);
        step(1);
        main_rst_an_i = 1'b1;
        ns = start_log.size();
        step(100);
        chk("midrst_no_frame", 32'(start_log.size() - ns), 0);
        chk("midrst_idle_tx", 32'(tx_o), 1);

        // Randomized words, configuration and enable
        for (int i = 0; i < 60; i++) begin
            int gap;
            div_i   = DIVW'($urandom_range(0, 3));
            par_i   = 2'($urandom_range(0, 3));
            stop2_i = 1'($urandom_range(0, 1));
            en_i    = ($urandom_range(0, 9) != 0) || (exp_q.size() >= DEPTH);
            gap     = $urandom_range(0, 4);
            if (gap > 0) step(gap);
            push(DW'($urandom));
        end
        en_i = 1'b1;
        wait_drain(20000);
        chk("final_busy", 32'(busy_o), 0);
        chk("final_tx", 32'(tx_o), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
